// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding and
// default geometry. Derived address-field widths live in the modules.
package icache_pkg;

   localparam int unsigned ICACHE_LINES          = 8;
   localparam int unsigned ICACHE_WORDS_PER_LINE = 4;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the instruction cache: valid bits, tags and data words.
// One combinational read port, one word write port plus a tag write.
// Valid bits clear asynchronously on reset and synchronously on clear_all.
module icache_line_array #(
   parameter int unsigned LINES          = 8,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned IDX_W          = 3,
   parameter int unsigned WORD_W         = 2,
   parameter int unsigned TAG_W          = 25
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              clear_all,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [WORD_W-1:0] rd_word,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [31:0]       rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [WORD_W-1:0] wr_word,
   input  logic [31:0]       wr_data,
   input  logic              tag_we,
   input  logic [TAG_W-1:0]  tag_wdata,
   input  logic              set_valid
);

   logic [LINES-1:0]                           valid;
   logic [LINES-1:0][TAG_W-1:0]                tags;
   logic [LINES-1:0][WORDS_PER_LINE-1:0][31:0] data;

   // Valid bits: clear beats set so a flush on the last refill beat wins
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         valid <= '0;
      else if (clear_all)
         valid <= '0;
      else if (set_valid)
         valid[wr_idx] <= 1'b1;
   end

   // Tag and data storage need no reset; valid gates every use
   always_ff @(posedge clk) begin
      if (tag_we)
         tags[wr_idx] <= tag_wdata;
      if (wr_en)
         data[wr_idx][wr_word] <= wr_data;
   end

   // Combinational read port
   always_comb begin
      rd_valid = valid[rd_idx];
      rd_tag   = tags[rd_idx];
      rd_data  = data[rd_idx][rd_word];
   end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits return the word
// combinationally; misses stall fetch and refill the whole line in order
// from word 0 over a req/ack word interface.
// Optional: ICACHE_STATS_EN adds hit_count / miss_count outputs.
module inst_cache
   import icache_pkg::*;
#(
   parameter int unsigned LINES          = ICACHE_LINES,
   parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] inst_addr,
   input  logic        flush,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned TAG_W  = 30 - WORD_W - IDX_W;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

   fill_state_t state, state_nxt;

   logic [WORD_W-1:0] word;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              unused_addr_bits;

   logic [TAG_W-1:0]  fill_tag;
   logic [IDX_W-1:0]  fill_idx;
   logic [WORD_W-1:0] count;
   logic              aborted;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [31:0]       rd_data;

   logic              lookup_match;
   logic              miss_start;
   logic              beat_ack;
   logic              last_beat;

   assign word             = inst_addr[2 +: WORD_W];
   assign idx              = inst_addr[2 + WORD_W +: IDX_W];
   assign tag              = inst_addr[31 -: TAG_W];
   assign unused_addr_bits = ^inst_addr[1:0];

   assign lookup_match = rd_valid && (rd_tag == tag);
   // A flush cycle neither hits nor launches a refill; the lookup retries next cycle
   assign miss_start   = (state == IDLE) && !flush && !lookup_match;
   assign beat_ack     = (state == FILL) && mem_ack;
   assign last_beat    = beat_ack && (count == LAST_WORD);

   icache_line_array #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IDX_W          (IDX_W),
      .WORD_W         (WORD_W),
      .TAG_W          (TAG_W)
   ) u_array (
      .clk       (clk),
      .rst_b     (rst_b),
      .clear_all (flush),
      .rd_idx    (idx),
      .rd_word   (word),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (beat_ack),
      .wr_idx    (fill_idx),
      .wr_word   (count),
      .wr_data   (mem_rdata),
      .tag_we    (last_beat),
      .tag_wdata (fill_tag),
      .set_valid (last_beat && !aborted && !flush)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state: leave IDLE on a miss, return after the last beat
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (miss_start) state_nxt = FILL;
         FILL:    if (last_beat)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: fetch-side result and refill request
   always_comb begin
      inst_valid = lookup_match && (state == IDLE) && !flush;
      inst       = inst_valid ? rd_data : 32'h0000_0000;
      stall      = !inst_valid;
      mem_req    = (state == FILL);
      mem_addr   = mem_req ? {fill_tag, fill_idx, count, 2'b00} : 32'h0000_0000;
   end

   // Refill bookkeeping: capture line on miss, count beats, note aborts
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fill_tag <= '0;
         fill_idx <= '0;
         count    <= '0;
         aborted  <= 1'b0;
      end else if (miss_start) begin
         fill_tag <= tag;
         fill_idx <= idx;
         count    <= '0;
         aborted  <= 1'b0;
      end else if (state == FILL) begin
         if (flush)
            aborted <= 1'b1;
         if (beat_ack)
            count <= count + 1'b1;
      end
   end

`ifdef ICACHE_STATS_EN
   // Hit and miss event counters, free-running modulo 2^32
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (inst_valid)
            hit_count <= hit_count + 32'd1;
         if (miss_start)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hits, conflict eviction,
// flush in IDLE and mid-fill, slow memory, async reset during a refill.
module tb_inst_cache;

   logic        clk;
   logic        rst_b;
   logic [31:0] inst_addr;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          n_checks = 0;
   int          n_errs   = 0;

   // memory responder state
   logic [31:0] salt     = 32'h0;
   logic [31:0] exp_base = 32'h0;
   int          beat     = 0;
   int          phase    = 0;
   int          lat      = 1;
   int          acks     = 0;
   int          flush_beat = -1;

   inst_cache dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .inst_addr  (inst_addr),
      .flush      (flush),
      .inst       (inst),
      .inst_valid (inst_valid),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Memory model: acks every lat-th request cycle, data = salt + word address
   task automatic drive_mem();
      logic ack;
      ack = 1'b0;
      if (mem_req) begin
         chk("mem_addr", mem_addr, exp_base + 32'(beat) * 32'd4);
         if (phase == lat - 1) begin
            ack   = 1'b1;
            phase = 0;
         end else begin
            phase++;
         end
      end
      mem_ack   = ack;
      mem_rdata = ack ? salt + (mem_addr >> 2) : 32'hDEAD_BEEF;
      if (flush_beat == -2) begin
         flush      = 1'b0;
         flush_beat = -1;
      end
      if (ack && flush_beat >= 0 && beat == flush_beat) begin
         flush      = 1'b1;
         flush_beat = -2;
      end
      if (ack) begin
         beat = (beat + 1) % 4;
         acks++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_mem();
      #1;
   endtask

   // Present an address and count stall cycles until the hit
   task automatic fetch(input logic [31:0] a, input int exp_cycles,
                        input logic [31:0] exp_inst, input string tag);
      int n;
      n         = 0;
      inst_addr = a;
      exp_base  = a & ~32'hF;
      beat      = 0;
      phase     = 0;
      #1;
      while (!inst_valid && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_cycles));
      chk({tag, "_inst"}, inst, exp_inst);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_b     = 1'b0;
      inst_addr = 32'h0;
      flush     = 1'b0;
      mem_rdata = 32'h0;
      mem_ack   = 1'b0;
      #2;
      chk("rst_stall",    {31'h0, stall},      32'h1);
      chk("rst_valid",    {31'h0, inst_valid}, 32'h0);
      chk("rst_inst",     inst,                32'h0);
      chk("rst_mem_req",  {31'h0, mem_req},    32'h0);
      chk("rst_mem_addr", mem_addr,            32'h0);
      @(posedge clk);
      #2;
      rst_b = 1'b1;

      // cold miss: 5 stall cycles, then word 0
      salt = 32'h1111_0000;
      fetch(32'h0, 5, 32'h1111_0000, "cold");
      chk("cold_valid", {31'h0, inst_valid}, 32'h1);

      // same-line hits, combinational
      inst_addr = 32'h8; #1;
      chk("hit8_inst",  inst,               32'h1111_0002);
      chk("hit8_req",   {31'h0, mem_req},   32'h0);
      chk("hit8_stall", {31'h0, stall},     32'h0);
      inst_addr = 32'hC; #1;
      chk("hitC_inst",  inst,               32'h1111_0003);

      // conflict eviction at index 0
      salt = 32'h2222_0000;
      fetch(32'h80, 5, 32'h2222_0020, "evict");
      inst_addr = 32'h84; #1;
      chk("evict_84", inst, 32'h2222_0021);
      inst_addr = 32'h0; #1;
      chk("evicted0_valid", {31'h0, inst_valid}, 32'h0);
      chk("evicted0_inst",  inst,                32'h0);
      salt = 32'h3333_0000;
      fetch(32'h0, 5, 32'h3333_0000, "refill0");

      // flush on the 2nd beat: fill completes, line invalid, refetch refills
      salt       = 32'h4444_0000;
      acks       = 0;
      flush_beat = 1;
      fetch(32'h10, 10, 32'h4444_0004, "flushfill");
      chk("flushfill_acks", 32'(acks), 32'd8);
      inst_addr = 32'h1C; #1;
      chk("flushfill_1C", inst, 32'h4444_0007);

      // flush in IDLE: no hit during flush, line cleared afterwards
      inst_addr = 32'h10;
      flush     = 1'b1; #1;
      chk("idleflush_valid", {31'h0, inst_valid}, 32'h0);
      chk("idleflush_inst",  inst,                32'h0);
      tick();
      flush = 1'b0; #1;
      chk("idleflush_after", {31'h0, inst_valid}, 32'h0);
      salt = 32'h5555_0000;
      fetch(32'h10, 5, 32'h5555_0004, "postflush");

      // slow memory: ack every 3rd cycle, address held between acks
      lat  = 3;
      salt = 32'h6666_0000;
      fetch(32'h28, 13, 32'h6666_000A, "slow");
      inst_addr = 32'h20; #1;
      chk("slow_w0", inst, 32'h6666_0008);
      inst_addr = 32'h2C; #1;
      chk("slow_w3", inst, 32'h6666_000B);
      lat = 1;

      // async reset in the middle of a refill
      salt      = 32'h7777_0000;
      inst_addr = 32'h44;
      exp_base  = 32'h40;
      beat      = 0;
      phase     = 0;
      tick();
      tick();
      tick();
      chk("prerst_req", {31'h0, mem_req}, 32'h1);
      rst_b   = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("asyncrst_req",   {31'h0, mem_req}, 32'h0);
      chk("asyncrst_addr",  mem_addr,         32'h0);
      chk("asyncrst_stall", {31'h0, stall},   32'h1);
      rst_b = 1'b1;
      #1;
      salt = 32'h8888_0000;
      fetch(32'h44, 5, 32'h8888_0011, "postrst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
